// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_gshare
//  Description : Dynamic branch direction predictor for the 5-stage MIPS core.
//                PHT of 2-bit saturating counters indexed by PC (bimodal) or
//                PC XOR global history (gshare). It keeps speculative and
//                committed global histories and repairs the speculative one
//                on a misprediction. It predicts in Decode and trains in Memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_gshare #(
    parameter int IDX_W = 8,
    parameter int GHR_W = 8,
    parameter int MODE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flushD,
    input  logic [31:0] pcF,
    input  logic        branchD,
    input  logic        branchM,
    input  logic [31:0] pcM,
    input  logic        actual_takeM,
    input  logic        pred_takeM,
    output logic        pred_takeD,
    output logic        mispredictM
);

    localparam int c_ENTRIES = 1 << IDX_W;

    logic [31:0]      r_pcD;
    logic             r_validD;
    logic [GHR_W-1:0] r_spec_ghr;
    logic [GHR_W-1:0] r_commit_ghr;
    logic [1:0]       r_pht [c_ENTRIES];

    logic [IDX_W-1:0] w_spec_ext;
    logic [IDX_W-1:0] w_commit_ext;
    logic [IDX_W-1:0] w_idx_d;
    logic [IDX_W-1:0] w_idx_m;
    logic [1:0]       w_cnt_d;
    logic [1:0]       w_cnt_m;
    logic [1:0]       w_cnt_next;
    logic [GHR_W-1:0] w_spec_shift;
    logic [GHR_W-1:0] w_commit_shift;
    logic             w_decode_shift;

    // Only PC bits [IDX_W+1:2] feed the index; the rest are carried for clarity.
    logic w_unused;
    assign w_unused = &{1'b0, pcF, pcM, r_pcD};

    // Zero-extend the histories to index width and form both PHT indices.
    always_comb begin
        w_spec_ext                = '0;
        w_spec_ext[GHR_W-1:0]     = r_spec_ghr;
        w_commit_ext              = '0;
        w_commit_ext[GHR_W-1:0]   = r_commit_ghr;
        w_idx_d = r_pcD[IDX_W+1:2] ^ ((MODE == 1) ? w_spec_ext   : '0);
        w_idx_m = pcM[IDX_W+1:2]   ^ ((MODE == 1) ? w_commit_ext : '0);
    end

    assign w_cnt_d     = r_pht[w_idx_d];
    assign w_cnt_m     = r_pht[w_idx_m];
    assign pred_takeD  = r_validD & w_cnt_d[1];
    assign mispredictM = branchM & (pred_takeM ^ actual_takeM);

    assign w_decode_shift = branchD & r_validD & ~stallD & ~flushD;

    // Shift-in of a new outcome; a single-bit history is simply replaced.
    generate
        if (GHR_W == 1) begin : g_ghr_single
            assign w_spec_shift   = pred_takeD;
            assign w_commit_shift = actual_takeM;
        end else begin : g_ghr_multi
            assign w_spec_shift   = {r_spec_ghr[GHR_W-2:0], pred_takeD};
            assign w_commit_shift = {r_commit_ghr[GHR_W-2:0], actual_takeM};
        end
    endgenerate

    // Saturating counter step for the resolving branch's entry.
    always_comb begin
        w_cnt_next = w_cnt_m;
        if (actual_takeM) begin
            if (w_cnt_m != 2'b11) w_cnt_next = w_cnt_m + 2'b01;
        end else begin
            if (w_cnt_m != 2'b00) w_cnt_next = w_cnt_m - 2'b01;
        end
    end

    // Decode capture register: flush wins over stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcD    <= '0;
            r_validD <= 1'b0;
        end else if (flushD) begin
            r_validD <= 1'b0;
        end else if (!stallD) begin
            r_pcD    <= pcF;
            r_validD <= 1'b1;
        end
    end

    // Global histories: misprediction restore overrides a Decode shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spec_ghr   <= '0;
            r_commit_ghr <= '0;
        end else begin
            if (branchM) r_commit_ghr <= w_commit_shift;
            if (mispredictM)         r_spec_ghr <= w_commit_shift;
            else if (w_decode_shift) r_spec_ghr <= w_spec_shift;
        end
    end

    // Pattern history table: train the resolving branch's counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) r_pht[i] <= 2'b01;
        end else if (branchM) begin
            r_pht[w_idx_m] <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_gshare
//  Description : Self-checking bench: directed table, hand sequences and
//                randomized traffic against a behavioural predictor model.
//                A bimodal and a gshare instance share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_gshare;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallD = 0, flushD = 0, branchD = 0, branchM = 0;
    logic        actual_takeM = 0, pred_takeM = 0;
    logic [31:0] pcF = '0, pcM = '0;
    logic        pred_b, mis_b, pred_g, mis_g;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor_gshare #(.IDX_W(4), .GHR_W(2), .MODE(0)) dut_b (
        .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcF(pcF),
        .branchD(branchD), .branchM(branchM), .pcM(pcM),
        .actual_takeM(actual_takeM), .pred_takeM(pred_takeM),
        .pred_takeD(pred_b), .mispredictM(mis_b));

    branch_predictor_gshare #(.IDX_W(4), .GHR_W(2), .MODE(1)) dut_g (
        .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcF(pcF),
        .branchD(branchD), .branchM(branchM), .pcM(pcM),
        .actual_takeM(actual_takeM), .pred_takeM(pred_takeM),
        .pred_takeD(pred_g), .mispredictM(mis_g));

    // ---------------- behavioural model (index 0 = bimodal, 1 = gshare) ----
    int          m_pht [2][16];
    int          m_spec [2];
    int          m_commit [2];
    bit          m_valid;
    logic [31:0] m_pcD;

    function automatic int midx(int mode, logic [31:0] pc, int h);
        int base = int'((pc >> 2) % 16);
        return (mode == 1) ? (base ^ h) : base;
    endfunction

    function automatic bit mpred(int m);
        return m_valid && (m_pht[m][midx(m, m_pcD, m_spec[m])] >= 2);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) m_pht[m][i] = 1;
            m_spec[m]   = 0;
            m_commit[m] = 0;
        end
        m_valid = 0;
        m_pcD   = '0;
    endtask

    task automatic model_update();
        bit mis = branchM && (pred_takeM != actual_takeM);
        for (int m = 0; m < 2; m++) begin
            bit p = mpred(m);
            int newc = (m_commit[m] * 2 + int'(actual_takeM)) % 4;
            if (branchM) begin
                int i = midx(m, pcM, m_commit[m]);
                if (actual_takeM) m_pht[m][i] = (m_pht[m][i] == 3) ? 3 : m_pht[m][i] + 1;
                else              m_pht[m][i] = (m_pht[m][i] == 0) ? 0 : m_pht[m][i] - 1;
                m_commit[m] = newc;
            end
            if (mis) m_spec[m] = newc;
            else if (branchD && m_valid && !stallD && !flushD)
                m_spec[m] = (m_spec[m] * 2 + int'(p)) % 4;
        end
        if (flushD) m_valid = 0;
        else if (!stallD) begin
            m_pcD   = pcF;
            m_valid = 1;
        end
    endtask

    task automatic chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check(string tag);
        bit mis = branchM && (pred_takeM != actual_takeM);
        chk({tag, " pred bimodal"}, pred_b, mpred(0));
        chk({tag, " pred gshare"},  pred_g, mpred(1));
        chk({tag, " mis bimodal"},  mis_b,  mis);
        chk({tag, " mis gshare"},   mis_g,  mis);
    endtask

    task automatic drive(bit st, bit fl, logic [31:0] pf, bit bd,
                         bit bm, logic [31:0] pm_pc, bit act, bit pm);
        stallD = st; flushD = fl; pcF = pf; branchD = bd;
        branchM = bm; pcM = pm_pc; actual_takeM = act; pred_takeM = pm;
    endtask

    // Inputs already driven: check at negedge, advance model at posedge.
    task automatic run_cycle(string tag);
        @(negedge clk);
        model_check(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- directed table for the gshare instance ----------------
    typedef struct {
        bit          st, fl;
        logic [31:0] pf;
        bit          bd, bm;
        logic [31:0] pm_pc;
        bit          act, pm;
        bit          exp_pred, exp_mis;
    } vec_t;

    localparam logic [31:0] c_PC_A = 32'h0040_0010;
    localparam logic [31:0] c_PC_B = 32'h0040_0008;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{0, 0, c_PC_A, 0, 0, c_PC_A, 0, 0, 0, 0};
        tbl[1] = '{0, 0, c_PC_A, 1, 1, c_PC_A, 1, 0, 0, 1}; // restore spec=01
        tbl[2] = '{0, 0, c_PC_A, 1, 1, c_PC_A, 0, 0, 0, 0}; // idx5 down, shift 0
        tbl[3] = '{0, 0, c_PC_A, 1, 1, c_PC_A, 1, 1, 0, 0}; // idx6 up
        tbl[4] = '{1, 0, c_PC_B, 1, 0, c_PC_A, 0, 0, 1, 0}; // idx4=10, stall
        tbl[5] = '{1, 1, c_PC_B, 1, 0, c_PC_A, 0, 0, 1, 0}; // flush beats stall
        tbl[6] = '{0, 0, c_PC_B, 0, 0, c_PC_A, 0, 0, 0, 0}; // invalid
        tbl[7] = '{0, 0, c_PC_B, 0, 1, c_PC_B, 1, 1, 0, 0}; // trains idx3
        tbl[8] = '{0, 0, c_PC_B, 0, 0, c_PC_B, 0, 0, 0, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset pred gshare", pred_g, 1'b0);
        chk("reset pred bimodal", pred_b, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].st, tbl[i].fl, tbl[i].pf, tbl[i].bd,
                  tbl[i].bm, tbl[i].pm_pc, tbl[i].act, tbl[i].pm);
            @(negedge clk);
            chk($sformatf("table[%0d] pred", i), pred_g, tbl[i].exp_pred);
            chk($sformatf("table[%0d] mis", i),  mis_g,  tbl[i].exp_mis);
            model_check($sformatf("table[%0d] model", i));
            @(posedge clk);
            model_update();
            #1;
        end

        // Bimodal training and saturation on one PC held in Decode.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, c_PC_A, 0, 1, c_PC_A, 1, 0);
            run_cycle("bimodal train");
        end
        drive(0, 0, c_PC_A, 0, 0, c_PC_A, 0, 0);
        @(negedge clk);
        chk("bimodal saturated pred", pred_b, 1'b1);

        // Asynchronous reset mid-cycle: outputs drop immediately.
        #2 rst = 1'b1;
        #1;
        chk("mid reset pred bimodal", pred_b, 1'b0);
        chk("mid reset pred gshare",  pred_g, 1'b0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, c_PC_B, 1, 0, c_PC_A, 0, 0);
        run_cycle("post reset capture");
        drive(0, 0, c_PC_B, 1, 0, c_PC_A, 0, 0);
        run_cycle("post reset predict");

        // Same-entry read/write: Decode sees old value now, new value next.
        drive(0, 0, c_PC_B, 0, 1, c_PC_B, 1, 1);
        run_cycle("same entry write");
        drive(0, 0, c_PC_B, 0, 0, c_PC_B, 0, 0);
        run_cycle("same entry after");

        // Mispredict repair with a simultaneous Decode shift.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, c_PC_B, 1, 1, c_PC_B, 1, 1);
            run_cycle("repair warmup");
        end
        drive(0, 0, c_PC_B, 1, 1, c_PC_B, 0, 1);
        run_cycle("repair mispredict");
        drive(0, 0, c_PC_B, 1, 0, c_PC_B, 0, 0);
        run_cycle("repair after");

        // Randomized traffic over a small PC window to force aliasing.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  32'h0040_0000 + 32'($urandom_range(0, 31)) * 4,
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
                  32'h0040_0000 + 32'($urandom_range(0, 31)) * 4,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
